// File: rtl/conv_window_gen.sv
// conv_window_gen: raster pixel stream to 3x3xIN_CH valid-padding windows via two line buffers and a tap register
// Optional CONV_WINGEN_POS_EN adds win_row/win_col (window top-left coordinate).
module conv_window_gen #(
  parameter int DATA_W = 8,
  parameter int IN_CH  = 3,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        pix_valid,
  input  logic                        sof,
  input  logic [IN_CH*DATA_W-1:0]     pix_in,
  output logic                        valid_out,
  output logic [IN_CH*DATA_W*9-1:0]   window_out,
  output logic                        frame_done
`ifdef CONV_WINGEN_POS_EN
  ,
  output logic [$clog2(IMG_H)-1:0]    win_row,
  output logic [$clog2(IMG_W)-1:0]    win_col
`endif
);
  localparam int PW = IN_CH * DATA_W;
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  logic [RW-1:0]   row, pos_r;
  logic [CW-1:0]   col, pos_c;
  logic [PW-1:0]   lb1 [IMG_W];
  logic [PW-1:0]   lb2 [IMG_W];
  logic [PW-1:0]   lb1_q, lb2_q;
  logic [PW-1:0]   tap [3][3];
  logic [PW-1:0]   nt  [3][3];
  logic [PW*9-1:0] win_nxt;
  logic            last_c, last_r, emit;

  // sof forces the accepted pixel to (0,0), abandoning any partial frame
  always_comb begin
    pos_r  = sof ? '0 : row;
    pos_c  = sof ? '0 : col;
    lb1_q  = lb1[pos_c];
    lb2_q  = lb2[pos_c];
    last_c = pos_c == CW'(IMG_W - 1);
    last_r = pos_r == RW'(IMG_H - 1);
    emit   = pix_valid && pos_r >= RW'(2) && pos_c >= CW'(2);
    for (int r = 0; r < 3; r++) begin
      nt[r][0] = tap[r][1];
      nt[r][1] = tap[r][2];
    end
    nt[0][2] = lb2_q;
    nt[1][2] = lb1_q;
    nt[2][2] = pix_in;
    win_nxt = '0;
    for (int c = 0; c < IN_CH; c++)
      for (int k = 0; k < 9; k++)
        win_nxt[(c*9+k)*DATA_W +: DATA_W] = nt[k/3][k%3][c*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk)
    if (pix_valid) begin
      lb2[pos_c] <= lb1_q;
      lb1[pos_c] <= pix_in;
    end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      row        <= '0;
      col        <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      window_out <= '0;
      tap        <= '{default: '0};
`ifdef CONV_WINGEN_POS_EN
      win_row    <= '0;
      win_col    <= '0;
`endif
    end else begin
      valid_out  <= emit;
      frame_done <= pix_valid && !sof && last_r && last_c;
      if (pix_valid) begin
        tap <= nt;
        col <= last_c ? '0 : pos_c + CW'(1);
        row <= last_c ? (last_r ? '0 : pos_r + RW'(1)) : pos_r;
      end
      if (emit) begin
        window_out <= win_nxt;
`ifdef CONV_WINGEN_POS_EN
        win_row    <= pos_r - RW'(2);
        win_col    <= pos_c - CW'(2);
`endif
      end
    end
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed checks of conv_window_gen on 5x5 frames, IN_CH=1 and IN_CH=3 side by side
module tb_conv_window_gen;
  logic         clk = 1'b0, rstn = 1'b0, pix_valid = 1'b0, sof = 1'b0;
  logic [7:0]   pix1 = '0;
  logic [23:0]  pix3 = '0;
  logic         v1, v3, d1, d3;
  logic [71:0]  w1;
  logic [215:0] w3;
`ifdef CONV_WINGEN_POS_EN
  logic [2:0]   r1, c1, r3, c3;
`endif
  int           n_cmp = 0, n_err = 0, wins = 0, dones = 0;
  logic [255:0] e1 = '0, e3 = '0;

  always #5 clk = ~clk;

  conv_window_gen #(.DATA_W(8), .IN_CH(1), .IMG_W(5), .IMG_H(5)) dut1 (
    .clk(clk), .rstn(rstn), .pix_valid(pix_valid), .sof(sof), .pix_in(pix1),
    .valid_out(v1), .window_out(w1), .frame_done(d1)
`ifdef CONV_WINGEN_POS_EN
    , .win_row(r1), .win_col(c1)
`endif
  );

  conv_window_gen #(.DATA_W(8), .IN_CH(3), .IMG_W(5), .IMG_H(5)) dut3 (
    .clk(clk), .rstn(rstn), .pix_valid(pix_valid), .sof(sof), .pix_in(pix3),
    .valid_out(v3), .window_out(w3), .frame_done(d3)
`ifdef CONV_WINGEN_POS_EN
    , .win_row(r3), .win_col(c3)
`endif
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] exp_win(input int ch, input int tr, input int tc, input int base);
    logic [255:0] e = '0;
    for (int c = 0; c < ch; c++)
      for (int k = 0; k < 9; k++)
        e[(c*9+k)*8 +: 8] = 8'(base + 5*(tr + k/3) + tc + k%3 + 64*c);
    return e;
  endfunction

  task automatic step(input bit pv, input bit s, input int r, input int c, input int base);
    bit ev, ed;
    int v;
    v = base + 5*r + c;
    pix_valid = pv;
    sof = s;
    pix1 = 8'(v);
    pix3 = {8'(v + 128), 8'(v + 64), 8'(v)};
    @(posedge clk);
    #1;
    ev = pv && r >= 2 && c >= 2;
    ed = pv && !s && r == 4 && c == 4;
    if (ev) begin
      e1 = exp_win(1, r - 2, c - 2, base);
      e3 = exp_win(3, r - 2, c - 2, base);
    end
    check("valid_out", v1, ev);
    check("valid_out_ch3", v3, ev);
    check("frame_done", d1, ed);
    check("frame_done_ch3", d3, ed);
    check("window_ch1", w1, e1);
    check("window_ch3", w3, e3);
`ifdef CONV_WINGEN_POS_EN
    if (ev) begin
      check("win_row", r1, r - 2);
      check("win_col", c1, c - 2);
      check("win_row_ch3", r3, r - 2);
      check("win_col_ch3", c3, c - 2);
    end
`endif
    if (v1) wins++;
    if (d1) dones++;
    pix_valid = 1'b0;
    sof = 1'b0;
  endtask

  task automatic send_frame(input int base, input bit first_sof, input int bub, input int npix);
    for (int i = 0; i < npix; i++) begin
      while ($urandom_range(99) < bub) step(1'b0, 1'b0, 0, 0, base);
      step(1'b1, first_sof && i == 0, i / 5, i % 5, base);
    end
  endtask

  task automatic counts(input string tag, input int ew, input int ed);
    check({tag, "_windows"}, wins, ew);
    check({tag, "_frame_done"}, dones, ed);
    wins = 0;
    dones = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", v1, 0);
    check("rst_window", w1, 0);
    check("rst_done", d1, 0);
    check("rst_window_ch3", w3, 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    // continuous frame
    send_frame(0, 1'b1, 0, 25);
    counts("t1", 9, 1);
    check("t1_last_window", w1, 72'h18_17_16_13_12_11_0e_0d_0c);
    // bubbles
    send_frame(0, 1'b1, 40, 25);
    counts("t2", 9, 1);
    // sof re-asserted at (3,1) of frame A
    send_frame(0, 1'b1, 0, 16);
    counts("t3a", 3, 0);
    send_frame(100, 1'b1, 0, 25);
    counts("t3b", 9, 1);
    check("t3b_last_window", w1, 72'h7c_7b_7a_77_76_75_72_71_70);
    // back-to-back, second frame without sof
    send_frame(0, 1'b1, 0, 25);
    send_frame(0, 1'b0, 0, 25);
    counts("t4", 18, 2);
    // reset at pixel (2,3)
    send_frame(0, 1'b1, 0, 13);
    counts("t5a", 1, 0);
    rstn = 1'b0;
    #1;
    check("t5_rst_valid", v1, 0);
    check("t5_rst_window", w1, 0);
    check("t5_rst_window_ch3", w3, 0);
    check("t5_rst_done", d1, 0);
    e1 = '0;
    e3 = '0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    send_frame(0, 1'b0, 0, 25);
    counts("t5b", 9, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
Upstream feeder for the convolution output stage. Takes a raster-order multi-channel pixel stream and builds 3x3xIN_CH windows using two line buffers and a 3x3 tap register. It emits one valid-padding ("valid" convolution) window per cycle, packed exactly as the convolution stage's window input expects.

Parameters:
DATA_W, 8, bits per pixel per channel
IN_CH, 3, input channels per pixel
IMG_W, 32, frame width in pixels (>=3)
IMG_H, 32, frame height in pixels (>=3)

Ports:
clk  input  1  clock; all logic on the rising edge
rstn  input  1  asynchronous active-low reset
pix_valid  input  1  pix_in/sof carry an accepted pixel this cycle
sof  input  1  start of frame; qualified by pix_valid
pix_in  input  IN_CH*DATA_W  pixel; channel c at [c*DATA_W +: DATA_W]
valid_out  output  1  window_out holds a new window (1-cycle pulse)
window_out  output  IN_CH*DATA_W*9  window; tap (c,k) at [(c*9+k)*DATA_W +: DATA_W], k=3*r+x, r=0 top row, x=0 left column
frame_done  output  1  1-cycle pulse; last pixel of the frame was accepted

Behaviour:
- Reset: valid_out=0, window_out=0, frame_done=0, row=col=0, tap register=0. Line buffer contents are not reset; they are never observable before being rewritten.
- No backpressure. A pixel is accepted iff pix_valid=1. With pix_valid=0 all state freezes and valid_out/frame_done are 0.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) give the position of the accepted pixel. col wraps to 0 and increments row. At (IMG_H-1, IMG_W-1) both wrap to 0.
- sof=1 with pix_valid=1: this pixel is (0,0) regardless of counters. Any partial frame is abandoned and none of its further windows are emitted. sof without pix_valid is ignored.
- Line buffers: lb1[col] holds row-1 and lb2[col] holds row-2, each IMG_W entries of IN_CH*DATA_W. On accept at column col: read both at col, then write lb2[col]<=old lb1[col] and lb1[col]<=pix_in.
- Tap register: the three columns shift left by one. The new right column (x=2) is {r0: old lb2[col], r1: old lb1[col], r2: pix_in}.
- valid_out=1 and window_out updated in the cycle after accepting pixel (row,col) with row>=2 and col>=2. Latency is 1 cycle. The window covers rows row-2..row and cols col-2..col.
- window_out holds its value between valid pulses.
- Each frame yields exactly (IMG_W-2)*(IMG_H-2) windows. Stale taps from the previous row are fully shifted out by col=2.
- frame_done pulses in the cycle after accepting (IMG_H-1, IMG_W-1), coincident with the final valid_out. A pixel arriving with sof=1 never asserts frame_done, even if the counters happened to sit at the last position.
- Back-to-back frames need no gap. The first two rows of the next frame emit nothing.
- Reset mid-frame: returns immediately to the reset state. The next accepted pixel is (0,0) whether or not sof is set.

Optional Feature:
Macro CONV_WINGEN_POS_EN.
- Defined: adds outputs win_row [$clog2(IMG_H)-1:0] and win_col [$clog2(IMG_W)-1:0]. They give the window's top-left coordinate (row-2, col-2), registered alongside window_out, reset to 0, and updated only with valid_out.
- Not defined: the ports do not exist and behaviour is otherwise identical.

Test Plan:
Common setup: IMG_W=IMG_H=5, IN_CH=1, DATA_W=8, pixel value = 5*row+col, sof on the first pixel.
- Continuous 25-pixel frame -> exactly 9 valid_out pulses. First window (after pixel (2,2)) = {0,1,2,5,6,7,10,11,12}; last = {12,13,14,17,18,19,22,23,24}. frame_done is coincident with the 9th pulse.
- Same frame with pix_valid=0 inserted at random (~40%) -> identical window sequence and count. No valid_out or frame_done during bubbles.
- sof reasserted at pixel (3,1) of frame A, then a full frame B (values +100) -> no further A windows. B's first window = {100,101,102,105,106,107,110,111,112}, and B yields 9 windows.
- Two frames back-to-back, no gap, second without sof -> 18 windows total, two frame_done pulses.
- rstn low for 2 cycles at pixel (2,3) -> outputs 0 immediately. The restarted frame produces the correct 9 windows.
- IN_CH=3, channel c value = 5*row+col+64*c -> tap (c,0) of the first window = 64*c, checked via the packing formula. With CONV_WINGEN_POS_EN, the first window reports win_row=0, win_col=0 and the last reports 2,2.
